// File: rtl/stride_selector_pipe.sv
// stride_selector_pipe: adds a configurable signed stride column to an
// iteration vector. A DIMENSION x NUM_STRIDES stride matrix is loaded
// column-major over conf_bus, then a valid/ready pipeline with one
// register stage produces x_bus + selected stride column.
//
// Optional build macro STRIDE_SELECT_ONEHOT_CHECK_EN:
//   defined   - multi-hot stride_select uses the lowest set column only
//               and raises the sticky sel_error flag.
//   undefined - multi-hot stride_select ORs the selected columns per row;
//               sel_error is tied low.
module stride_selector_pipe #(
  parameter int                    DIMENSION                = 3,
  parameter int                    NUM_STRIDES              = 4,
  parameter int                    ITERATION_VARIABLE_WIDTH = 16,
  parameter int                    MATRIX_ELEMENT_WIDTH     = 8,
  parameter int                    SELECT_WIDTH             = 3,
  parameter logic [SELECT_WIDTH-1:0] SELECT_ID              = 3'b011
) (
  input  logic                                         conf_clk,
  input  logic                                         reset,
  input  logic [MATRIX_ELEMENT_WIDTH-1:0]              conf_bus,
  input  logic [SELECT_WIDTH-1:0]                      sel,
  input  logic                                         conf_restart,
  output logic                                         conf_ack,
  input  logic                                         in_valid,
  output logic                                         in_ready,
  input  logic [DIMENSION*ITERATION_VARIABLE_WIDTH-1:0] x_bus,
  input  logic [NUM_STRIDES-1:0]                       stride_select,
  output logic                                         out_valid,
  input  logic                                         out_ready,
  output logic [DIMENSION*ITERATION_VARIABLE_WIDTH-1:0] ivar_next,
  output logic                                         sel_error
);

  localparam int IVW   = ITERATION_VARIABLE_WIDTH;
  localparam int MEW   = MATRIX_ELEMENT_WIDTH;
  localparam int ROW_W = (DIMENSION   > 1) ? $clog2(DIMENSION)   : 1;
  localparam int COL_W = (NUM_STRIDES > 1) ? $clog2(NUM_STRIDES) : 1;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic               ack_q, ack_d;
  logic               write_en;
  logic [MEW-1:0]     s_q [DIMENSION][NUM_STRIDES];

  logic               xfer;
  logic               out_valid_q;
  logic [DIMENSION*IVW-1:0] ivar_q;
  logic [DIMENSION*IVW-1:0] sum_bus;
  logic [NUM_STRIDES-1:0]   col_mask;
  logic [MEW-1:0]           elem_sel [DIMENSION];

  assign conf_ack  = ack_q;
  assign out_valid = out_valid_q;
  assign ivar_next = ivar_q;
  assign in_ready  = (state_q == RUN) && (!out_valid_q || out_ready);
  assign xfer      = in_valid && in_ready;

  // State, write pointer and acknowledge registers
  always_ff @(posedge conf_clk or negedge reset) begin
    if (!reset) begin
      state_q <= LOAD;
      row_q   <= '0;
      col_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      ack_q   <= ack_d;
    end
  end

  // Load sequencing: column-major pointer walk; restart has priority over a write
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    ack_d    = ack_q;
    write_en = 1'b0;
    case (state_q)
      LOAD: begin
        if (conf_restart) begin
          row_d = '0;
          col_d = '0;
        end else if (sel == SELECT_ID) begin
          write_en = 1'b1;
          if (row_q == ROW_W'(DIMENSION - 1)) begin
            row_d = '0;
            if (col_q == COL_W'(NUM_STRIDES - 1)) begin
              col_d   = '0;
              state_d = RUN;
              ack_d   = 1'b1;
            end else begin
              col_d = col_q + COL_W'(1);
            end
          end else begin
            row_d = row_q + ROW_W'(1);
          end
        end
      end
      RUN: begin
        if (conf_restart) begin
          state_d = LOAD;
          row_d   = '0;
          col_d   = '0;
          ack_d   = 1'b0;
        end
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  // Stride matrix storage, written only while loading
  always_ff @(posedge conf_clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned r = 0; r < DIMENSION; r++) begin
        for (int unsigned c = 0; c < NUM_STRIDES; c++) begin
          s_q[r][c] <= '0;
        end
      end
    end else if (write_en) begin
      s_q[row_q][col_q] <= conf_bus;
    end
  end

`ifdef STRIDE_SELECT_ONEHOT_CHECK_EN
  // Two's-complement trick isolates the lowest set column
  assign col_mask = stride_select & (~stride_select + NUM_STRIDES'(1));

  logic multi_hot;
  logic sel_error_q;
  assign multi_hot = |(stride_select & (stride_select - NUM_STRIDES'(1)));
  assign sel_error = sel_error_q;

  // Sticky flag for multi-hot selects seen on accepted transfers
  always_ff @(posedge conf_clk or negedge reset) begin
    if (!reset) begin
      sel_error_q <= 1'b0;
    end else if (xfer && multi_hot) begin
      sel_error_q <= 1'b1;
    end
  end
`else
  assign col_mask  = stride_select;
  assign sel_error = 1'b0;
`endif

  // Per-row OR of masked columns (single column when the mask is one-hot)
  always_comb begin
    for (int unsigned r = 0; r < DIMENSION; r++) begin
      elem_sel[r] = '0;
      for (int unsigned c = 0; c < NUM_STRIDES; c++) begin
        if (col_mask[c]) begin
          elem_sel[r] = elem_sel[r] | s_q[r][c];
        end
      end
    end
  end

  // Sign-extend the stride element and add with wraparound; row 0 is the MSB slice
  always_comb begin
    sum_bus = '0;
    for (int unsigned r = 0; r < DIMENSION; r++) begin
      sum_bus[(DIMENSION-r)*IVW-1 -: IVW] =
        x_bus[(DIMENSION-r)*IVW-1 -: IVW] +
        {{(IVW-MEW){elem_sel[r][MEW-1]}}, elem_sel[r]};
    end
  end

  // Output register stage: loads on transfer, drains on out_ready
  always_ff @(posedge conf_clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      ivar_q      <= '0;
    end else if (xfer) begin
      out_valid_q <= 1'b1;
      ivar_q      <= sum_bus;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stride_selector_pipe.sv
// Self-checking bench for stride_selector_pipe (default parameters).
// Honours STRIDE_SELECT_ONEHOT_CHECK_EN for multi-hot expectations.
module tb_stride_selector_pipe;

`ifdef STRIDE_SELECT_ONEHOT_CHECK_EN
  localparam bit ONEHOT = 1'b1;
`else
  localparam bit ONEHOT = 1'b0;
`endif

  logic        conf_clk = 1'b0;
  logic        reset;
  logic [7:0]  conf_bus;
  logic [2:0]  sel;
  logic        conf_restart;
  logic        conf_ack;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] x_bus;
  logic [3:0]  stride_select;
  logic        out_valid;
  logic        out_ready;
  logic [47:0] ivar_next;
  logic        sel_error;

  int tests = 0;
  int fails = 0;

  logic [7:0]  load_vals [12];
  logic [7:0]  mat [3][4];
  logic [47:0] sb [$];

  typedef struct {
    logic [47:0] x;
    logic [3:0]  ss;
    logic [47:0] exp;
  } vec_t;
  vec_t vecs [7];

  stride_selector_pipe #(
    .DIMENSION(3),
    .NUM_STRIDES(4),
    .ITERATION_VARIABLE_WIDTH(16),
    .MATRIX_ELEMENT_WIDTH(8),
    .SELECT_WIDTH(3),
    .SELECT_ID(3'b011)
  ) dut (
    .conf_clk(conf_clk),
    .reset(reset),
    .conf_bus(conf_bus),
    .sel(sel),
    .conf_restart(conf_restart),
    .conf_ack(conf_ack),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .x_bus(x_bus),
    .stride_select(stride_select),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .ivar_next(ivar_next),
    .sel_error(sel_error)
  );

  always #5 conf_clk = ~conf_clk;

  function automatic logic [47:0] pk(input logic [15:0] a, input logic [15:0] b,
                                     input logic [15:0] c);
    return {a, b, c};
  endfunction

  // Reference: pick columns (lowest only in one-hot mode), OR, sign-extend, add
  function automatic logic [47:0] model(input logic [47:0] x, input logic [3:0] ss);
    logic [3:0]  m;
    logic        found;
    logic [7:0]  e;
    logic [47:0] res;
    m = ss;
    if (ONEHOT) begin
      m = 4'b0000;
      found = 1'b0;
      for (int c = 0; c < 4; c++) begin
        if (ss[c] && !found) begin
          m[c] = 1'b1;
          found = 1'b1;
        end
      end
    end
    res = '0;
    for (int r = 0; r < 3; r++) begin
      e = 8'h00;
      for (int c = 0; c < 4; c++) if (m[c]) e = e | mat[r][c];
      res[47-16*r -: 16] = x[47-16*r -: 16] + {{8{e[7]}}, e};
    end
    return res;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge conf_clk);
    #1;
  endtask

  task automatic load_matrix(input bit with_stray);
    for (int i = 0; i < 12; i++) begin
      if (with_stray && i == 6) begin
        sel = 3'b001;
        conf_bus = 8'h55;
        step();
        check("stray_no_ack", 64'(conf_ack), 64'd0);
      end
      sel = 3'b011;
      conf_bus = load_vals[i];
      step();
      check($sformatf("load_ack_%0d", i), 64'(conf_ack), (i == 11) ? 64'd1 : 64'd0);
    end
    sel = 3'b000;
    conf_bus = 8'h00;
  endtask

  // Scoreboard: push on accepted input, pop/compare on accepted output
  always @(negedge conf_clk) begin
    if (!reset) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_unexpected: got %h expected none", ivar_next);
        end else begin
          check("sb_out", 64'(ivar_next), 64'(sb.pop_front()));
        end
      end
      if (in_valid && in_ready) sb.push_back(model(x_bus, stride_select));
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    load_vals = '{8'h01, 8'h00, 8'h00, 8'hFD, 8'h01, 8'h00,
                  8'h00, 8'hFC, 8'h01, 8'h00, 8'h00, 8'h02};
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 3; r++) mat[r][c] = load_vals[c*3 + r];

    vecs[0] = '{pk(16'd5, 16'd7, 16'd9), 4'b0010, pk(16'd2, 16'd8, 16'd9)};
    vecs[1] = '{pk(16'hFFFF, 16'h0, 16'h0), 4'b0001, pk(16'h0000, 16'h0, 16'h0)};
    vecs[2] = '{pk(16'h1234, 16'hABCD, 16'h0007), 4'b0000, pk(16'h1234, 16'hABCD, 16'h0007)};
    vecs[3] = '{pk(16'h0, 16'h0, 16'h0), 4'b0110,
                ONEHOT ? pk(16'hFFFD, 16'h0001, 16'h0000) : pk(16'hFFFD, 16'hFFFD, 16'h0001)};
    vecs[4] = '{pk(16'h000A, 16'h0014, 16'h001E), 4'b1000, pk(16'h000A, 16'h0014, 16'h0020)};
    vecs[5] = '{pk(16'h0, 16'h0, 16'h0), 4'b0100, pk(16'h0000, 16'hFFFC, 16'h0001)};
    vecs[6] = '{pk(16'h7FFF, 16'h0000, 16'h0001), 4'b1111,
                ONEHOT ? pk(16'h8000, 16'h0000, 16'h0001) : pk(16'h7FFC, 16'hFFFD, 16'h0004)};

    reset = 1'b0;
    conf_bus = '0;
    sel = '0;
    conf_restart = 1'b0;
    in_valid = 1'b0;
    x_bus = '0;
    stride_select = '0;
    out_ready = 1'b0;
    step();
    step();
    check("rst_ack", 64'(conf_ack), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_ivar", 64'(ivar_next), 64'd0);
    check("rst_sel_error", 64'(sel_error), 64'd0);
    reset = 1'b1;
    step();
    check("load_in_ready", 64'(in_ready), 64'd0);

    load_matrix(1'b1);
    check("run_in_ready", 64'(in_ready), 64'd1);

    // Back-to-back vectors with downstream always ready
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      x_bus = vecs[i].x;
      stride_select = vecs[i].ss;
      step();
      check($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
      check($sformatf("vec%0d_ivar", i), 64'(ivar_next), 64'(vecs[i].exp));
      check($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'd1);
    end
    check("sel_error_multi", 64'(sel_error), ONEHOT ? 64'd1 : 64'd0);
    in_valid = 1'b0;
    step();
    check("drain_valid", 64'(out_valid), 64'd0);

    // Backpressure: result held, no second transfer until drain
    out_ready = 1'b0;
    in_valid = 1'b1;
    x_bus = pk(16'd1, 16'd2, 16'd3);
    stride_select = 4'b0001;
    step();
    check("bp_first", 64'(ivar_next), 64'(pk(16'd2, 16'd2, 16'd3)));
    x_bus = pk(16'd4, 16'd5, 16'd6);
    stride_select = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bp_in_ready_%0d", i), 64'(in_ready), 64'd0);
      step();
      check($sformatf("bp_hold_%0d", i), 64'(ivar_next), 64'(pk(16'd2, 16'd2, 16'd3)));
      check($sformatf("bp_valid_%0d", i), 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    #1;
    check("bp_in_ready_release", 64'(in_ready), 64'd1);
    step();
    check("bp_second", 64'(ivar_next), 64'(pk(16'd4, 16'd1, 16'd7)));
    check("bp_second_valid", 64'(out_valid), 64'd1);
    in_valid = 1'b0;
    step();
    check("bp_drain", 64'(out_valid), 64'd0);
    check("sel_error_sticky", 64'(sel_error), ONEHOT ? 64'd1 : 64'd0);

    // Restart in RUN together with a transfer: transfer accepted, held through LOAD
    out_ready = 1'b0;
    in_valid = 1'b1;
    conf_restart = 1'b1;
    x_bus = pk(16'd100, 16'd200, 16'd300);
    stride_select = 4'b0001;
    step();
    in_valid = 1'b0;
    conf_restart = 1'b0;
    check("rs_ack", 64'(conf_ack), 64'd0);
    check("rs_in_ready", 64'(in_ready), 64'd0);
    check("rs_ivar", 64'(ivar_next), 64'(pk(16'd101, 16'd200, 16'd300)));
    step();
    step();
    check("rs_held_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    step();
    check("rs_drained", 64'(out_valid), 64'd0);
    check("rs_in_ready_load", 64'(in_ready), 64'd0);

    // Reset after five writes: partial matrix discarded, full reload needed
    sel = 3'b011;
    for (int i = 0; i < 5; i++) begin
      conf_bus = load_vals[i];
      step();
    end
    sel = 3'b000;
    reset = 1'b0;
    #1;
    check("mid_rst_ack", 64'(conf_ack), 64'd0);
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_sel_error", 64'(sel_error), 64'd0);
    step();
    reset = 1'b1;
    load_matrix(1'b0);

    in_valid = 1'b1;
    x_bus = pk(16'd5, 16'd7, 16'd9);
    stride_select = 4'b0010;
    step();
    check("reload_ivar", 64'(ivar_next), 64'(pk(16'd2, 16'd8, 16'd9)));
    in_valid = 1'b0;
    step();
    step();
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stride_selector_pipe.md
STRIDE_SELECTOR_PIPE -- requirements
Module: stride_selector_pipe

Interface
REQ-001 SHALL have parameter DIMENSION, default 3: number of iteration variables (rows of stride matrix).
REQ-002 SHALL have parameter NUM_STRIDES, default 4: number of stride columns, independent of DIMENSION.
REQ-003 SHALL have parameter ITERATION_VARIABLE_WIDTH, default 16: width of each iteration variable.
REQ-004 SHALL have parameter MATRIX_ELEMENT_WIDTH, default 8: width of each signed stride element.
REQ-005 SHALL have parameter SELECT_WIDTH, default 3: width of sel.
REQ-006 SHALL have parameter SELECT_ID, default 3'b011: sel value addressing this block.
REQ-007 SHALL have ports:
  conf_clk  input  1  single clock, all state on rising edge
  reset  input  1  asynchronous, active-low reset
  conf_bus  input  MATRIX_ELEMENT_WIDTH  stride element write data
  sel  input  SELECT_WIDTH  configuration select
  conf_restart  input  1  pulse: discard matrix, re-enter loading
  conf_ack  output  1  matrix fully loaded
  in_valid  input  1  x_bus/stride_select valid
  in_ready  output  1  block accepts input this cycle
  x_bus  input  DIMENSION*ITERATION_VARIABLE_WIDTH  current iteration vector, element 0 at MSB slice
  stride_select  input  NUM_STRIDES  column select, bit 0 = column 0
  out_valid  output  1  ivar_next valid
  out_ready  input  1  downstream accepts ivar_next
  ivar_next  output  DIMENSION*ITERATION_VARIABLE_WIDTH  next iteration vector, same packing as x_bus
  sel_error  output  1  sticky multi-hot select flag

Function
REQ-008 SHALL implement FSM with states LOAD and RUN; LOAD after reset.
REQ-009 In LOAD, each cycle with sel==SELECT_ID SHALL write conf_bus into s[row][col], column-major order (row 0..DIMENSION-1 within column 0, then column 1, ...); cycles with other sel values SHALL write nothing and hold the write pointer.
REQ-010 On the write of s[DIMENSION-1][NUM_STRIDES-1] SHALL move to RUN and assert conf_ack on the following cycle; exactly DIMENSION*NUM_STRIDES writes required.
REQ-011 In RUN, writes SHALL be ignored and the matrix held.
REQ-012 conf_restart in RUN SHALL, next cycle, return to LOAD, clear conf_ack, reset write pointer to (0,0); matrix contents retained until overwritten. conf_restart in LOAD SHALL reset the write pointer only.
REQ-013 in_ready SHALL equal (state==RUN) and (out_valid==0 or out_ready==1); combinational from registered state and out_ready only.
REQ-014 Input transfer occurs when in_valid and in_ready; the output register SHALL load next cycle (latency 1), out_valid=1.
REQ-015 out_valid SHALL clear on out_ready with no new transfer; ivar_next SHALL hold stable while out_valid=1 and out_ready=0.
REQ-016 ivar_next[r] SHALL be x_bus[r] plus the selected stride element sign-extended to ITERATION_VARIABLE_WIDTH, modulo 2^ITERATION_VARIABLE_WIDTH (wrap, no saturation).
REQ-017 stride_select all-zero SHALL add zero (ivar_next = x_bus).
REQ-018 conf_restart with a simultaneous transfer SHALL accept that transfer; any held output remains valid through LOAD until taken.

Reset
REQ-019 reset low SHALL asynchronously force: state LOAD, write pointer (0,0), all s elements 0, conf_ack 0, out_valid 0, ivar_next 0, sel_error 0; in_ready thus 0.
REQ-020 reset mid-load or mid-transfer SHALL discard partial matrix and in-flight output; no transfer completes in the reset cycle.

Configuration
REQ-021 Macro STRIDE_SELECT_ONEHOT_CHECK_EN defined: multi-hot stride_select on a transfer SHALL use lowest-index set column only and set sel_error (sticky until reset).
REQ-022 Macro undefined: multi-hot stride_select SHALL bitwise-OR the selected column elements per row before sign extension; sel_error tied 0.

Verification
REQ-023 Load 3x4 matrix col0=(1,0,0), col1=(-3,1,0), col2=(0,-4,1), col3=(0,0,2) with sel=011, one stray sel=001 cycle mid-load -> conf_ack=1 exactly one cycle after 12th valid write, stray ignored.
REQ-024 x_bus=(5,7,9), stride_select=4'b0010, out_ready=1 -> next cycle out_valid=1, ivar_next=(2,8,9); in_ready stays 1.
REQ-025 x_bus=(16'hFFFF,0,0), stride_select=4'b0001 -> ivar_next=(16'h0000,0,0) (wrap); stride_select=0 -> ivar_next=x_bus.
REQ-026 out_ready=0 for 3 cycles with in_valid=1 -> first result held stable, in_ready=0, no second transfer until out_ready=1; then next vector loads same cycle as drain.
REQ-027 stride_select=4'b0110, x_bus=(0,0,0): with macro -> ivar_next=(-3,1,0), sel_error=1 persisting; without macro -> ivar_next=(16'hFFFD,16'hFFFD,1) per OR of 8'hFD|8'h00, 8'h01|8'hFC, 8'h00|8'h01, sel_error=0.
REQ-028 reset low after 5 of 12 writes, then release -> conf_ack=0, out_valid=0, full 12 writes needed again; conf_restart in RUN -> conf_ack=0 next cycle, in_ready=0 until reload completes.
